gamma_lut_ctrl: RTL and testbench

Frame-synchronous controller for a run-time-loadable gamma mapping stage on the gray video stream (vsync/href/8-bit gray). It holds two 256-entry gamma tables: one active and used for lookup, one shadow and writable by the host. Bank swaps and bypass changes happen only at frame start, so a frame is never mapped with a mixed curve. It sits between the sensor-side gray stream and downstream processing, replacing a fixed combinational gamma curve.

---
 rtl/gamma_lut_ctrl.sv | 148 ++++++++++++++
 tb/tb_gamma_lut_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_lut_ctrl.sv
// Frame-synchronous gamma lookup on the gray stream with two run-time-loadable tables
// (active + host-writable shadow); bank swaps and bypass changes take effect only at frame start.
module gamma_lut_ctrl #(
    parameter int DW          = 8,
    parameter bit INIT_BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          per_img_vsync,
    input  logic          per_img_href,
    input  logic [DW-1:0] per_img_gray,
    input  logic          lut_wr_en,
    input  logic [DW-1:0] lut_wr_addr,
    input  logic [DW-1:0] lut_wr_data,
    input  logic          lut_swap_req,
    input  logic          bypass,
    output logic          post_img_vsync,
    output logic          post_img_href,
    output logic [DW-1:0] post_img_gray,
    output logic          lut_swap_pend,
    output logic          lut_bank
);

    localparam int DEPTH = 1 << DW;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_FRAME
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_frame_start;
    logic   w_in_frame;

    logic r_bank;
    logic r_pend;
    logic r_bypass;

    logic          r_s1_vsync;
    logic          r_s1_href;
    logic [DW-1:0] r_s1_gray;
    logic          r_s1_bank;
    logic          r_s1_bypass;

    logic          r_out_vsync;
    logic          r_out_href;
    logic [DW-1:0] r_out_gray;

    // Both banks share one array; the MSB of the address selects the bank.
    logic [DW-1:0] r_lut [0:2*DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_frame_start = 1'b0;
        w_in_frame    = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (!per_img_vsync) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (per_img_vsync) begin
                    w_next_state  = ST_FRAME;
                    w_frame_start = 1'b1;
                end
            end
            ST_FRAME: begin
                w_in_frame = 1'b1;
                if (!per_img_vsync) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_SYNC;
            end
        endcase
    end

    // A request arriving in the frame-start cycle itself swaps immediately and never sets pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank   <= 1'b0;
            r_pend   <= 1'b0;
            r_bypass <= INIT_BYPASS;
        end else if (w_frame_start) begin
            if (r_pend || lut_swap_req) begin
                r_bank <= ~r_bank;
            end
            r_pend   <= 1'b0;
            r_bypass <= bypass;
        end else if (lut_swap_req) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (lut_wr_en) begin
            r_lut[{~r_bank, lut_wr_addr}] <= lut_wr_data;
        end
    end

    // Bank and bypass travel with the pixel so a frame-start change never splits a pixel's config.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vsync  <= 1'b0;
            r_s1_href   <= 1'b0;
            r_s1_gray   <= '0;
            r_s1_bank   <= 1'b0;
            r_s1_bypass <= 1'b0;
        end else begin
            r_s1_vsync  <= per_img_vsync & w_in_frame;
            r_s1_href   <= per_img_href & per_img_vsync & w_in_frame;
            r_s1_gray   <= per_img_gray;
            r_s1_bank   <= r_bank;
            r_s1_bypass <= r_bypass;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vsync <= 1'b0;
            r_out_href  <= 1'b0;
            r_out_gray  <= '0;
        end else begin
            r_out_vsync <= r_s1_vsync;
            r_out_href  <= r_s1_href;
            r_out_gray  <= r_s1_bypass ? r_s1_gray : r_lut[{r_s1_bank, r_s1_gray}];
        end
    end

    assign post_img_vsync = r_out_vsync;
    assign post_img_href  = r_out_href;
    assign post_img_gray  = r_out_gray;
    assign lut_swap_pend  = r_pend;
    assign lut_bank       = r_bank;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Scoreboard bench for gamma_lut_ctrl: a spec-level model predicts each output, queued two cycles
// ahead, plus table-driven mapped-pixel vectors and hand-written swap/reset sequences.
module tb_gamma_lut_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       per_img_vsync = 1'b0;
    logic       per_img_href = 1'b0;
    logic [7:0] per_img_gray = 8'h00;
    logic       lut_wr_en = 1'b0;
    logic [7:0] lut_wr_addr = 8'h00;
    logic [7:0] lut_wr_data = 8'h00;
    logic       lut_swap_req = 1'b0;
    logic       bypass = 1'b0;
    logic       post_img_vsync;
    logic       post_img_href;
    logic [7:0] post_img_gray;
    logic       lut_swap_pend;
    logic       lut_bank;

    gamma_lut_ctrl #(.DW(8), .INIT_BYPASS(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .per_img_vsync  (per_img_vsync),
        .per_img_href   (per_img_href),
        .per_img_gray   (per_img_gray),
        .lut_wr_en      (lut_wr_en),
        .lut_wr_addr    (lut_wr_addr),
        .lut_wr_data    (lut_wr_data),
        .lut_swap_req   (lut_swap_req),
        .bypass         (bypass),
        .post_img_vsync (post_img_vsync),
        .post_img_href  (post_img_href),
        .post_img_gray  (post_img_gray),
        .lut_swap_pend  (lut_swap_pend),
        .lut_bank       (lut_bank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       h;
        logic [7:0] g;
        logic       gChk;
    } item_t;

    typedef struct packed {
        logic [7:0] pixIn;
        logic [7:0] pixOut;
    } vec_t;

    item_t sb[$];
    int    total = 0;
    int    bad = 0;

    // Reference model of the controller as seen from its ports.
    logic [7:0] mTab [0:1][0:255];
    bit         mValid [0:1][0:255];
    logic       mBank;
    logic       mPend;
    logic       mByp;
    int         mState;

    logic       reqBypass = 1'b0;
    logic       nWrEn = 1'b0;
    logic [7:0] nWrAddr = 8'h00;
    logic [7:0] nWrData = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mBank  = 1'b0;
        mPend  = 1'b0;
        mByp   = 1'b1;
    endtask

    task automatic scoreCycle();
        item_t it;
        if (sb.size() >= 2) begin
            it = sb.pop_front();
            checkOutput("vsync", 32'(post_img_vsync), 32'(it.v));
            checkOutput("href", 32'(post_img_href), 32'(it.h));
            if (it.gChk) begin
                checkOutput("gray", 32'(post_img_gray), 32'(it.g));
            end
        end
        checkOutput("bank", 32'(lut_bank), 32'(mBank));
        checkOutput("pend", 32'(lut_swap_pend), 32'(mPend));
    endtask

    // One clock of stimulus; ovr forces a constant expected gray instead of the model's.
    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] g,
                                 input logic swap, input logic ovr, input logic [7:0] ovrG);
        item_t it;
        per_img_vsync = v;
        per_img_href  = h;
        per_img_gray  = g;
        lut_swap_req  = swap;
        lut_wr_en     = nWrEn;
        lut_wr_addr   = nWrAddr;
        lut_wr_data   = nWrData;
        bypass        = reqBypass;

        it.v    = (mState == 2) && v;
        it.h    = (mState == 2) && v && h;
        it.g    = mByp ? g : mTab[mBank][g];
        it.gChk = it.h && (mByp || mValid[mBank][g]);
        if (ovr) begin
            it.g    = ovrG;
            it.gChk = it.h;
        end
        sb.push_back(it);

        if (nWrEn) begin
            mTab[~mBank][nWrAddr]   = nWrData;
            mValid[~mBank][nWrAddr] = 1'b1;
        end
        case (mState)
            0: if (!v) mState = 1;
            1: begin
                if (v) begin
                    mState = 2;
                    if (mPend || swap) mBank = ~mBank;
                    mPend = 1'b0;
                    mByp  = reqBypass;
                end else if (swap) begin
                    mPend = 1'b1;
                end
            end
            default: begin
                if (!v) mState = 1;
                if (swap) mPend = 1'b1;
            end
        endcase

        @(posedge clk);
        #1;
        lut_swap_req = 1'b0;
        lut_wr_en    = 1'b0;
        nWrEn        = 1'b0;
        scoreCycle();
    endtask

    task automatic doReset(input logic v);
        item_t z;
        rst           = 1'b1;
        per_img_vsync = v;
        per_img_href  = v;
        per_img_gray  = 8'h5A;
        lut_swap_req  = 1'b0;
        lut_wr_en     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        sb.delete();
        z = '0;
        sb.push_back(z);
        checkOutput("rstVsync", 32'(post_img_vsync), 32'd0);
        checkOutput("rstHref", 32'(post_img_href), 32'd0);
        checkOutput("rstGray", 32'(post_img_gray), 32'd0);
        checkOutput("rstBank", 32'(lut_bank), 32'd0);
        checkOutput("rstPend", 32'(lut_swap_pend), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pix(input logic [7:0] g);
        applyStimulus(1'b1, 1'b1, g, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pixExp(input logic [7:0] g, input logic [7:0] e);
        applyStimulus(1'b1, 1'b1, g, 1'b0, 1'b1, e);
    endtask

    initial begin
        vec_t vecs [0:5];
        vecs[0] = '{pixIn: 8'h10, pixOut: 8'hEF};
        vecs[1] = '{pixIn: 8'h00, pixOut: 8'hFF};
        vecs[2] = '{pixIn: 8'hFF, pixOut: 8'h00};
        vecs[3] = '{pixIn: 8'h80, pixOut: 8'h7F};
        vecs[4] = '{pixIn: 8'h01, pixOut: 8'hFE};
        vecs[5] = '{pixIn: 8'h5A, pixOut: 8'hA5};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) mValid[b][a] = 1'b0;
        modelReset();

        doReset(1'b0);
        idle(3);

        // Bypassed ramp frame: output equals input two cycles later.
        reqBypass = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) pix(8'(i));
        idle(3);

        // Load shadow bank 1 with an inverted curve, then request a swap.
        for (int a = 0; a < 256; a++) begin
            nWrEn   = 1'b1;
            nWrAddr = 8'(a);
            nWrData = 8'(255 - a);
            idle(1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        checkOutput("pendRise", 32'(lut_swap_pend), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        checkOutput("pendRepeat", 32'(lut_swap_pend), 32'd1);

        // Mapped frame through bank 1.
        reqBypass = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("bankSwapped", 32'(lut_bank), 32'd1);
        checkOutput("pendCleared", 32'(lut_swap_pend), 32'd0);
        for (int i = 0; i < 6; i++) pixExp(vecs[i].pixIn, vecs[i].pixOut);

        // Write into the shadow bank mid-frame; the active curve must not change.
        nWrEn   = 1'b1;
        nWrAddr = 8'h10;
        nWrData = 8'h00;
        pixExp(8'h10, 8'hEF);
        pixExp(8'h10, 8'hEF);

        // Swap requested mid-frame: rest of this frame keeps bank 1.
        applyStimulus(1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 8'hDF);
        checkOutput("pendMidFrame", 32'(lut_swap_pend), 32'd1);
        pixExp(8'h10, 8'hEF);
        pixExp(8'h30, 8'hCF);
        idle(3);
        checkOutput("bankHeld", 32'(lut_bank), 32'd1);

        // Next frame uses bank 0, which now reads 0x00 at 0x10.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("bankBack", 32'(lut_bank), 32'd0);
        pixExp(8'h10, 8'h00);
        pix(8'h11);
        idle(3);

        // Swap coincident with the vsync rise applies to that frame without pending.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        checkOutput("coincPend", 32'(lut_swap_pend), 32'd0);
        checkOutput("coincBank", 32'(lut_bank), 32'd1);
        pixExp(8'h10, 8'hEF);
        pixExp(8'hFF, 8'h00);
        checkOutput("coincPendLater", 32'(lut_swap_pend), 32'd0);

        // Reset mid-frame with vsync held high: nothing emitted until a fresh frame start.
        pix(8'h40);
        pix(8'h41);
        doReset(1'b1);
        for (int i = 0; i < 4; i++) pix(8'h33);
        checkOutput("noHrefAfterRst", 32'(post_img_href), 32'd0);
        idle(2);
        reqBypass = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) pixExp(8'(8'h05 + i), 8'(8'h05 + i));
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
